// File: rtl/moosic_pkg.sv
// Shared types and defaults for the moosic key loader: FSM state encoding,
// default key/chunk widths and the chunks-per-key helper.
package moosic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int KEY_SIZE_DEF = 16;
  localparam int CHUNK_DEF    = 4;

  function automatic int nchunk(input int key_size, input int chunk);
    return key_size / chunk;
  endfunction

endpackage

// File: rtl/moosic_prescaler.sv
// Reload-counter prescaler: emits a registered one-cycle tick every div+1
// enabled cycles, with the first tick on the first enabled cycle.
module moosic_prescaler #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_reg;

  // Dropping the enable parks the counter at zero so a fresh run strobes at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (!en) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (cnt_reg == '0) begin
      cnt_reg <= div;
      tick    <= 1'b1;
    end else begin
      cnt_reg <= cnt_reg - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/moosic_key_loader.sv
// Pin-side controller for the locked counter: assembles a key from chunks,
// commits it after an XOR checksum check, and gates the increment strobe.
module moosic_key_loader
  import moosic_pkg::*;
#(
  parameter int KEY_SIZE  = KEY_SIZE_DEF,
  parameter int CHUNK     = CHUNK_DEF,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 chunk_valid_i,
  input  logic [CHUNK-1:0]     chunk_i,
  input  logic                 incr_req_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic [KEY_SIZE-1:0]  key_o,
  output logic                 key_valid_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 incr_o
);

  localparam int NCHUNK = nchunk(KEY_SIZE, CHUNK);
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  state_t              state_reg;
  logic [KEY_SIZE-1:0] shadow_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [CHUNK-1:0]    xor_reg;
  logic [KEY_SIZE-1:0] key_reg;
  logic                key_valid_reg;
  logic                err_reg;
  logic                presc_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shadow_reg    <= '0;
      count_reg     <= '0;
      xor_reg       <= '0;
      key_reg       <= '0;
      key_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else if (start_i) begin
      // A restart wins over any same-cycle chunk; the old key stays on key_o.
      state_reg     <= LOAD;
      shadow_reg    <= '0;
      count_reg     <= '0;
      xor_reg       <= '0;
      key_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else if (chunk_valid_i) begin
      case (state_reg)
        LOAD: begin
          shadow_reg <= (shadow_reg << CHUNK) | KEY_SIZE'(chunk_i);
          xor_reg    <= xor_reg ^ chunk_i;
          count_reg  <= count_reg + CNT_W'(1);
          if (count_reg == CNT_W'(NCHUNK - 1)) state_reg <= CHECK;
        end
        CHECK: begin
          if (chunk_i == xor_reg) begin
            key_reg       <= shadow_reg;
            key_valid_reg <= 1'b1;
          end else begin
            err_reg <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= state_reg;
      endcase
    end
  end

  assign presc_en = incr_req_i && key_valid_reg && (state_reg == IDLE);

  moosic_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (presc_en),
    .div  (div_i),
    .tick (incr_o)
  );

  assign key_o       = key_reg;
  assign key_valid_o = key_valid_reg;
  assign busy_o      = (state_reg != IDLE);
  assign err_o       = err_reg;

endmodule
